// File: rtl/wb_data_packer.sv
// Packs WORD_WIDTH Wishbone strobes into DATA_WIDTH operands and buffers them in a small
// show-ahead FIFO. Configuration strobes are passed through as a one-cycle pulse.
module wb_data_packer #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic                        input_ready,
   input  logic [WORD_WIDTH-1:0]       wishbone_data,
   input  logic                        config_en,
   input  logic                        soft_clear,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        cfg_valid,
   output logic [WORD_WIDTH-1:0]       cfg_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int unsigned N    = DATA_WIDTH / WORD_WIDTH;
   localparam int unsigned WcW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WcW-1:0]        wc_q, wc_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_wr;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  cfg_valid_q, cfg_valid_d;
   logic [WORD_WIDTH-1:0] cfg_data_q, cfg_data_d;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic data_strobe;
   logic cfg_strobe;
   logic last_word;
   logic full;
   logic pop;
   logic push;
   logic push_accept;
   logic mem_we;

   always_comb begin
      data_strobe = input_ready & ~config_en;
      cfg_strobe  = input_ready & config_en;
      last_word   = (wc_q == WcW'(N - 1));
      full        = (count_q == CntW'(FIFO_DEPTH));
      out_valid   = (count_q != '0);
      pop         = out_valid & out_ready;
      push        = data_strobe & last_word;
      // A full FIFO still takes the new entry when the head leaves in the same cycle.
      push_accept = push & (~full | pop);
      mem_we      = push_accept & ~soft_clear & ~wb_rst_i;

      // acc_wr carries the incoming word in its slot; on the last word it is the packed entry.
      acc_wr = acc_q;
      for (int i = 0; i < int'(N); i++) begin
         if (wc_q == WcW'(i)) begin
            acc_wr[i*WORD_WIDTH +: WORD_WIDTH] = wishbone_data;
         end
      end
   end

   always_comb begin
      wc_d        = wc_q;
      acc_d       = acc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      cfg_valid_d = 1'b0;
      cfg_data_d  = cfg_data_q;

      if (soft_clear) begin
         wc_d       = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (cfg_strobe) begin
            cfg_valid_d = 1'b1;
            cfg_data_d  = wishbone_data;
         end
         if (data_strobe) begin
            acc_d = acc_wr;
            wc_d  = last_word ? '0 : wc_q + WcW'(1);
         end
         if (push && !push_accept) begin
            overflow_d = 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push_accept) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push_accept) - CntW'(pop);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wc_q        <= '0;
         acc_q       <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         cfg_valid_q <= 1'b0;
         cfg_data_q  <= '0;
      end else begin
         wc_q        <= wc_d;
         acc_q       <= acc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_data_q  <= cfg_data_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= acc_wr;
      end
   end

   // Storage is not reset, so the head is masked while empty to keep out_data at zero.
   assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
   assign cfg_valid  = cfg_valid_q;
   assign cfg_data   = cfg_data_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_data_packer.sv
// Directed and random stimulus for wb_data_packer, checked against a queue-based model.
module tb_wb_data_packer;

   localparam int unsigned WW    = 32;
   localparam int unsigned DW    = 128;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NW    = DW / WW;

   logic          clk = 1'b0;
   logic          rst;
   logic          input_ready;
   logic [WW-1:0] wishbone_data;
   logic          config_en;
   logic          soft_clear;
   logic          out_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          cfg_valid;
   logic [WW-1:0] cfg_data;
   logic [2:0]    fifo_count;
   logic          overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [WW-1:0] words_q[$];
   logic [DW-1:0] fifo_q[$];
   logic          m_ovf  = 1'b0;
   logic          m_cfgv = 1'b0;
   logic [WW-1:0] m_cfgd = '0;

   always #5 clk = ~clk;

   wb_data_packer #(
      .WORD_WIDTH(WW),
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .input_ready  (input_ready),
      .wishbone_data(wishbone_data),
      .config_en    (config_en),
      .soft_clear   (soft_clear),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .cfg_valid    (cfg_valid),
      .cfg_data     (cfg_data),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic ir, input logic [WW-1:0] d, input logic ce,
                        input logic sc, input logic ordy);
      logic          do_pop;
      logic [DW-1:0] entry;
      logic          do_push;
      do_push = 1'b0;
      entry   = '0;
      if (r) begin
         words_q.delete();
         fifo_q.delete();
         m_ovf  = 1'b0;
         m_cfgv = 1'b0;
         m_cfgd = '0;
      end else if (sc) begin
         words_q.delete();
         fifo_q.delete();
         m_ovf  = 1'b0;
         m_cfgv = 1'b0;
      end else begin
         do_pop = (fifo_q.size() != 0) && ordy;
         m_cfgv = ir && ce;
         if (ir && ce) m_cfgd = d;
         if (ir && !ce) begin
            words_q.push_back(d);
            if (words_q.size() == NW) begin
               for (int i = 0; i < int'(NW); i++) entry = entry | (DW'(words_q[i]) << (WW * i));
               words_q.delete();
               if (fifo_q.size() < DEPTH || do_pop) do_push = 1'b1;
               else m_ovf = 1'b1;
            end
         end
         if (do_pop) void'(fifo_q.pop_front());
         if (do_push) fifo_q.push_back(entry);
      end
   endtask

   task automatic tick(input logic r, input logic ir, input logic [WW-1:0] d, input logic ce,
                       input logic sc, input logic ordy);
      rst           = r;
      input_ready   = ir;
      wishbone_data = d;
      config_en     = ce;
      soft_clear    = sc;
      out_ready     = ordy;
      @(posedge clk);
      model(r, ir, d, ce, sc, ordy);
      #1;
      chk("out_valid", DW'(out_valid), DW'(fifo_q.size() != 0));
      if (fifo_q.size() != 0) chk("out_data", out_data, fifo_q[0]);
      chk("fifo_count", DW'(fifo_count), DW'(fifo_q.size()));
      chk("overflow", DW'(overflow), DW'(m_ovf));
      chk("cfg_valid", DW'(cfg_valid), DW'(m_cfgv));
      chk("cfg_data", DW'(cfg_data), DW'(m_cfgd));
   endtask

   task automatic idle(input logic ordy);
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0, ordy);
   endtask

   task automatic word(input logic [WW-1:0] d, input logic ordy);
      tick(1'b0, 1'b1, d, 1'b0, 1'b0, ordy);
   endtask

   task automatic packet_rand(input logic ordy);
      for (int i = 0; i < int'(NW); i++) word($urandom, ordy);
   endtask

   task automatic clear();
      tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset state
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
      chk("reset_out_data", out_data, '0);
      chk("reset_cfg_data", DW'(cfg_data), '0);

      // Basic packing, first word in the LSBs
      word(32'h1111_1111, 1'b0);
      word(32'h2222_2222, 1'b0);
      word(32'h3333_3333, 1'b0);
      word(32'h4444_4444, 1'b0);
      chk("pack4_data", out_data, 128'h44444444_33333333_22222222_11111111);
      chk("pack4_count", DW'(fifo_count), DW'(1));
      idle(1'b1);
      idle(1'b1);

      // Five packets into a four-deep FIFO, then drain
      for (int p = 0; p < 5; p++) packet_rand(1'b0);
      chk("ovf5_count", DW'(fifo_count), DW'(4));
      chk("ovf5_flag", DW'(overflow), DW'(1));
      for (int p = 0; p < 4; p++) idle(1'b1);
      chk("drained_valid", DW'(out_valid), '0);
      idle(1'b0);
      chk("sticky_ovf", DW'(overflow), DW'(1));
      clear();

      // Full FIFO with simultaneous push and pop
      for (int p = 0; p < 4; p++) packet_rand(1'b0);
      for (int i = 0; i < int'(NW) - 1; i++) word($urandom, 1'b0);
      word($urandom, 1'b1);
      chk("fullpp_count", DW'(fifo_count), DW'(4));
      chk("fullpp_ovf", DW'(overflow), '0);
      clear();

      // Config strobe in the middle of a packet
      word(32'h0000_0001, 1'b0);
      word(32'h0000_0002, 1'b0);
      tick(1'b0, 1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b0);
      chk("cfg_pulse", DW'(cfg_valid), DW'(1));
      chk("cfg_value", DW'(cfg_data), DW'(32'hA));
      word(32'h0000_0003, 1'b0);
      chk("cfg_one_cycle", DW'(cfg_valid), '0);
      word(32'h0000_0004, 1'b0);
      chk("cfg_packet", out_data, 128'h00000004_00000003_00000002_00000001);
      tick(1'b0, 1'b0, 32'h5, 1'b1, 1'b0, 1'b0);
      chk("cfg_no_strobe", DW'(cfg_valid), '0);
      clear();

      // Reset mid-packet discards partial words
      word(32'hAAAA_AAAA, 1'b0);
      word(32'hBBBB_BBBB, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) word(WW'(i), 1'b0);
      chk("rst_mid_packet", out_data, 128'h00000004_00000003_00000002_00000001);

      // Three entries with overflow set, then soft_clear alongside a strobe
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 5; p++) packet_rand(1'b0);
      idle(1'b1);
      chk("pre_clear_count", DW'(fifo_count), DW'(3));
      tick(1'b0, 1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b1);
      chk("clr_count", DW'(fifo_count), '0);
      chk("clr_valid", DW'(out_valid), '0);
      chk("clr_ovf", DW'(overflow), '0);
      for (int i = 5; i <= 8; i++) word(WW'(i), 1'b0);
      chk("clr_wc_zero", out_data, 128'h00000008_00000007_00000006_00000005);
      clear();

      // Random traffic
      for (int t = 0; t < 600; t++) begin
         logic r, ir, ce, sc, ordy;
         r    = ($urandom_range(0, 99) == 0);
         ir   = ($urandom_range(0, 3) != 0);
         ce   = ($urandom_range(0, 7) == 0);
         sc   = ($urandom_range(0, 39) == 0);
         ordy = ($urandom_range(0, 2) == 0);
         tick(r, ir, $urandom, ce, sc, ordy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
